display_scan: RTL and testbench

Six-digit multiplexed 7-segment driver for the digital clock. It takes the BCD hour, minute and second values from the hour counter (mod 24) and the minute/second counters, and drives one common-anode digit at a time. Inputs are snapshotted once per frame so digits never tear. Fields under adjustment blink, and an optional leading-zero blank applies to the hour tens digit.

---
 rtl/display_scan_if.sv | 22 ++
 rtl/display_scan.sv | 127 ++++++++++++
 tb/tb_display_scan.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// rtl/display_scan_if.sv - time inputs and display outputs of the 7-segment scanner
interface display_scan_if;
  logic       en;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       adjust_hour;
  logic       adjust_min;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  modport master (
    output en, hour, minute, second, adjust_hour, adjust_min,
    input  seg, dp, an
  );

  modport slave (
    input  en, hour, minute, second, adjust_hour, adjust_min,
    output seg, dp, an
  );
endinterface

// File: rtl/display_scan.sv
// rtl/display_scan.sv - six-digit multiplexed common-anode 7-segment clock display driver
module display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 83,
  parameter int LZB          = 1
) (
  input logic           clk_i,
  input logic           rst_i,
  display_scan_if.slave disp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [23:0]   snap_q, snap_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    an_q, an_d;

  logic       tick;
  logic       frame_end;
  logic [3:0] nibble;
  logic [6:0] glyph;
  logic       blank;

  assign tick      = disp.en && (div_q == DIV_LAST);
  assign frame_end = tick && (idx_q == 3'd5);

  // Scan position, per-frame snapshot and blink phase; everything freezes while en is low
  always_comb begin
    div_d         = div_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (disp.en) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      if (frame_end) begin
        snap_d = {disp.hour, disp.minute, disp.second};
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // Pick the current digit, decode it and work out blanking for the registered outputs
  always_comb begin
    case (idx_q)
      3'd0:    nibble = snap_q[23:20];
      3'd1:    nibble = snap_q[19:16];
      3'd2:    nibble = snap_q[15:12];
      3'd3:    nibble = snap_q[11:8];
      3'd4:    nibble = snap_q[7:4];
      default: nibble = snap_q[3:0];
    endcase

    case (nibble)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase

    // Adjust flags are live so the blink responds immediately; the leading-zero
    // test uses the snapshot so it matches the digit actually shown
    blank = (blink_phase_q && disp.adjust_hour && (idx_q <= 3'd1)) ||
            (blink_phase_q && disp.adjust_min && (idx_q == 3'd2 || idx_q == 3'd3)) ||
            ((LZB != 0) && (idx_q == 3'd0) && (snap_q[23:20] == 4'd0));

    an_d  = 6'b111111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (disp.en) begin
      an_d  = ~(6'b100000 >> idx_q);
      seg_d = blank ? 7'b1111111 : glyph;
      dp_d  = blank || !(idx_q == 3'd1 || idx_q == 3'd3);
    end
  end

  // State and output registers with synchronous reset to a blank display at slot 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q         <= '0;
      idx_q         <= 3'd0;
      snap_q        <= 24'h0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      an_q          <= 6'b111111;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;
  assign disp.an  = an_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - scoreboard bench for display_scan with a frame-arithmetic reference model
module tb_display_scan;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FR = 6 * SD;

  typedef struct packed {
    logic [5:0] an_a;
    logic [6:0] seg_a;
    logic       dp_a;
    logic [5:0] an_b;
    logic [6:0] seg_b;
    logic       dp_b;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] hour, minute, second;
  logic       adj_h, adj_m;

  int n_chk;
  int n_fail;

  exp_t exp_q[$];

  display_scan_if if_a ();
  display_scan_if if_b ();

  assign if_a.en = en;          assign if_b.en = en;
  assign if_a.hour = hour;      assign if_b.hour = hour;
  assign if_a.minute = minute;  assign if_b.minute = minute;
  assign if_a.second = second;  assign if_b.second = second;
  assign if_a.adjust_hour = adj_h; assign if_b.adjust_hour = adj_h;
  assign if_a.adjust_min = adj_m;  assign if_b.adjust_min = adj_m;

  display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(1)) dut_lzb (
    .clk_i(clk), .rst_i(rst), .disp(if_a.slave)
  );

  display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF), .LZB(0)) dut_nolzb (
    .clk_i(clk), .rst_i(rst), .disp(if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: display state is a pure function of the number of enabled cycles since reset
  initial begin : model
    int unsigned act;
    logic [23:0] snap_m;
    act = 0;
    snap_m = 24'h0;
    forever begin
      exp_t e;
      int slot, frame, phase;
      logic [3:0] nib;
      logic blink_blank, lz_blank;
      @(posedge clk);
      e = '{an_a: 6'h3f, seg_a: 7'h7f, dp_a: 1'b1, an_b: 6'h3f, seg_b: 7'h7f, dp_b: 1'b1};
      if (rst) begin
        act = 0;
        snap_m = 24'h0;
      end else if (en) begin
        slot  = int'((act / SD) % 6);
        frame = int'(act / FR);
        phase = (frame / BF) % 2;
        nib   = 4'(snap_m >> (20 - 4 * slot));
        blink_blank = (phase == 1) &&
                      ((adj_h && slot < 2) || (adj_m && (slot == 2 || slot == 3)));
        lz_blank = (slot == 0) && (snap_m[23:20] == 4'd0);
        e.an_a  = ~(6'b100000 >> slot);
        e.an_b  = e.an_a;
        e.seg_a = (blink_blank || lz_blank) ? 7'h7f : seg_of(nib);
        e.dp_a  = (blink_blank || lz_blank) ? 1'b1 : !(slot == 1 || slot == 3);
        e.seg_b = blink_blank ? 7'h7f : seg_of(nib);
        e.dp_b  = blink_blank ? 1'b1 : !(slot == 1 || slot == 3);
        if (act % FR == FR - 1) snap_m = {hour, minute, second};
        act++;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: each cycle's registered outputs are compared against the oldest expectation
  initial begin : monitor
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if ({if_a.an, if_a.seg, if_a.dp} !== {e.an_a, e.seg_a, e.dp_a}) begin
          n_fail++;
          $display("FAIL lzb1_out t=%0t an/seg/dp got %b/%b/%b expected %b/%b/%b",
                   $time, if_a.an, if_a.seg, if_a.dp, e.an_a, e.seg_a, e.dp_a);
        end
        n_chk++;
        if ({if_b.an, if_b.seg, if_b.dp} !== {e.an_b, e.seg_b, e.dp_b}) begin
          n_fail++;
          $display("FAIL lzb0_out t=%0t an/seg/dp got %b/%b/%b expected %b/%b/%b",
                   $time, if_b.an, if_b.seg, if_b.dp, e.an_b, e.seg_b, e.dp_b);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stimulus: directed scenarios first, then randomized traffic
  initial begin : stim
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; en = 1'b1;
    hour = 8'h00; minute = 8'h00; second = 8'h00;
    adj_h = 1'b0; adj_m = 1'b0;
    cyc(3);
    hour = 8'h12; minute = 8'h34; second = 8'h56;
    rst = 1'b0;
    cyc(2 * FR);
    cyc(10);
    minute = 8'h35;
    cyc(2 * FR);
    hour = 8'h09;
    cyc(2 * FR);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    adj_m = 1'b1;
    cyc(9 * FR);
    adj_m = 1'b0;
    cyc(2 * SD + 1);
    en = 1'b0;
    cyc(7);
    en = 1'b1;
    cyc(2 * FR);
    minute = 8'h3C;
    cyc(2 * FR + 5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    adj_h = 1'b1; adj_m = 1'b1;
    cyc(5 * FR);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        hour   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
        minute = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        second = 8'($urandom);
      end
      if ($urandom_range(0, 99) == 0) adj_h = ~adj_h;
      if ($urandom_range(0, 99) == 0) adj_m = ~adj_m;
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 799) == 0);
      cyc(1);
    end
    rst = 1'b0; en = 1'b1;
    cyc(3);
    n_chk++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL queue_drain pending got %0d expected at most 1", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
